// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states, lane geometry.
package mem_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// lane extraction and sign/zero extension of load data on the way back.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]       i_size,
  input  logic [1:0]       i_a_lo,
  input  logic             i_unsigned,
  input  logic [31:0]      i_wdata,
  input  logic [31:0]      i_rdata,
  output logic [LANES-1:0] o_be,
  output logic [31:0]      o_wdata,
  output logic [31:0]      o_rdata_ext
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  // Misaligned halves/words ignore the low address bits, so only a[1] picks the half lane.
  assign w_byte_sh = i_rdata >> {i_a_lo, 3'b000};
  assign w_half_sh = i_rdata >> {i_a_lo[1], 4'b0000};

  // Store side: byte enables and lane-replicated write data.
  always_comb begin
    o_be    = {LANES{1'b1}};
    o_wdata = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_a_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_a_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: extract the addressed lane and extend; words ignore i_unsigned.
  always_comb begin
    o_rdata_ext = i_rdata;
    case (i_size)
      SZ_BYTE: o_rdata_ext = {{24{w_byte_sh[7] & ~i_unsigned}}, w_byte_sh[7:0]};
      SZ_HALF: o_rdata_ext = {{16{w_half_sh[15] & ~i_unsigned}}, w_half_sh[15:0]};
      default: o_rdata_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/gnt/rvalid data-memory handshake and one writeback record per
// accepted instruction. Optional misalignment trap under `MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [1:0]    mem_size,
  input  logic          mem_unsigned,
  input  logic [AW-1:0] aluresult,
  input  logic [DW-1:0] dreg,
  input  logic [4:0]    rd_in,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_be,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wb_valid,
  output logic          wb_wen,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          exc_misalign
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_be;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [1:0]    r_a_lo;
  logic          r_wb_valid;
  logic          r_wb_wen;
  logic [4:0]    r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic          r_exc;

  logic          w_idle;
  logic          w_accept;
  logic          w_is_mem;
  logic          w_trap;
  logic [1:0]    w_al_size;
  logic [1:0]    w_al_a_lo;
  logic          w_al_unsigned;
  logic [3:0]    w_be;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata_ext;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = ex_valid & w_idle;
  assign w_is_mem = mem_rd | mem_wr;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = (mem_size == SZ_HALF && aluresult[0]) ||
                  (mem_size[1] && aluresult[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif

  // The aligner sees live EX operands in IDLE (store path) and the captured ones afterwards (load path).
  assign w_al_size     = w_idle ? mem_size        : r_size;
  assign w_al_a_lo     = w_idle ? aluresult[1:0]  : r_a_lo;
  assign w_al_unsigned = w_idle ? mem_unsigned    : r_unsigned;

  mem_align u_align (
    .i_size      (w_al_size),
    .i_a_lo      (w_al_a_lo),
    .i_unsigned  (w_al_unsigned),
    .i_wdata     (dreg),
    .i_rdata     (dmem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_rdata_ext)
  );

  // Next-state logic for the bus handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mem && !w_trap) w_state_nxt = S_REQ;
        else                                 w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (dmem_gnt) w_state_nxt = r_we ? S_IDLE : S_WAIT_R;
        else          w_state_nxt = S_REQ;
      end
      S_WAIT_R: begin
        if (dmem_rvalid) w_state_nxt = S_IDLE;
        else             w_state_nxt = S_WAIT_R;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, bus request registers and the writeback record.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 4'b0000;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_a_lo     <= 2'b00;
      r_wb_valid <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_exc      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_exc      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wb_rd    <= rd_in;
            r_size     <= mem_size;
            r_unsigned <= mem_unsigned;
            r_a_lo     <= aluresult[1:0];
            if (!w_is_mem) begin
              r_wb_valid <= 1'b1;
              r_wb_wen   <= 1'b1;
              r_wb_data  <= aluresult;
            end else if (w_trap) begin
              r_wb_valid <= 1'b1;
              r_exc      <= 1'b1;
              r_wb_data  <= aluresult;
            end else begin
              r_req   <= 1'b1;
              r_we    <= mem_wr;
              r_addr  <= {aluresult[AW-1:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_we) r_wb_valid <= 1'b1;
          end
        end
        S_WAIT_R: begin
          if (dmem_rvalid) begin
            r_wb_valid <= 1'b1;
            r_wb_wen   <= 1'b1;
            r_wb_data  <= w_rdata_ext;
          end
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign ex_ready     = w_idle;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign dmem_be      = r_be;
  assign wb_valid     = r_wb_valid;
  assign wb_wen       = r_wb_wen;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign exc_misalign = r_exc;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors, a queue of expected writeback records
// computed from access rules, and literal checks at the documented latencies.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_unsigned = 1'b0;
  logic [31:0] aluresult = 32'd0;
  logic [31:0] dreg = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misalign;

  int n_cmp = 0;
  int n_err = 0;
  logic started = 1'b0;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        exc;
  } exp_t;
  exp_t q[$];

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .aluresult(aluresult), .dreg(dreg), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misalign(exc_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written as plain arithmetic on the access description.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    if (sz == 2'd0)      r = (d & 32'hFF) * 32'h0101_0101;
    else if (sz == 2'd1) r = (d & 32'hFFFF) * 32'h0001_0001;
    else                 r = d;
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] a,
                                         input logic [31:0] rdat, input logic uns);
    int unsigned v;
    if (sz == 2'd0) begin
      v = (rdat / (32'd1 << (8 * a))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rdat / (32'd1 << (16 * (a / 2)))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdat;
    end
    return v;
  endfunction

  // Scoreboard: every writeback pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_wen", {31'd0, wb_wen}, {31'd0, e.wen});
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_exc", {31'd0, exc_misalign}, {31'd0, e.exc});
          if (e.chk_data) chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk("exc_quiet", {31'd0, exc_misalign}, 32'd0);
      end
    end
  end

  task automatic push(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                      input logic cd, input logic exc);
    exp_t e;
    e.wen = wen; e.rd = rd; e.data = data; e.chk_data = cd; e.exc = exc;
    q.push_back(e);
  endtask

  // One load/store with gnt after gd idle request cycles and rvalid rvd cycles after gnt.
  task automatic mem_op(input logic is_wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                        input int gd, input int rvd, input logic [31:0] rdat,
                        input logic [31:0] lit_addr, input logic [3:0] lit_be,
                        input logic [31:0] lit_wdata, input logic [31:0] lit_res);
    chk("ready_before", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b1; mem_rd = ~is_wr; mem_wr = is_wr; mem_size = sz; mem_unsigned = uns;
    aluresult = a; dreg = d; rd_in = rd;
    @(negedge clk);
    ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dreg = 32'hDEAD_BEEF; aluresult = 32'h0;
    chk("ready_busy", {31'd0, ex_ready}, 32'd0);
    chk("req_up", {31'd0, dmem_req}, 32'd1);
    chk("we", {31'd0, dmem_we}, {31'd0, is_wr});
    chk("addr_model", dmem_addr, a & 32'hFFFF_FFFC);
    chk("addr_lit", dmem_addr, lit_addr);
    chk("be_model", {28'd0, dmem_be}, {28'd0, m_be(sz, a[1:0])});
    chk("be_lit", {28'd0, dmem_be}, {28'd0, lit_be});
    if (is_wr) begin
      chk("wdata_model", dmem_wdata, m_wdata(sz, d));
      chk("wdata_lit", dmem_wdata, lit_wdata);
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, dmem_req}, 32'd1);
      chk("addr_hold", dmem_addr, lit_addr);
      chk("be_hold", {28'd0, dmem_be}, {28'd0, lit_be});
      if (is_wr) chk("wdata_hold", dmem_wdata, lit_wdata);
      chk("ready_wait_gnt", {31'd0, ex_ready}, 32'd0);
    end
    if (is_wr) push(1'b0, rd, 32'd0, 1'b0, 1'b0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    if (is_wr) begin
      chk("st_wb_pulse", {31'd0, wb_valid}, 32'd1);
      chk("st_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("st_ready", {31'd0, ex_ready}, 32'd1);
    end else begin
      chk("ld_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("ld_ready_busy", {31'd0, ex_ready}, 32'd0);
      for (int i = 1; i < rvd; i++) begin
        @(negedge clk);
        chk("ld_wait_r", {31'd0, ex_ready}, 32'd0);
        chk("ld_no_wb", {31'd0, wb_valid}, 32'd0);
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdat;
      push(1'b1, rd, m_load(sz, a[1:0], rdat, uns), 1'b1, 1'b0);
      @(negedge clk);
      dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      chk("ld_wb_pulse", {31'd0, wb_valid}, 32'd1);
      chk("ld_data_lit", wb_data, lit_res);
      chk("ld_ready", {31'd0, ex_ready}, 32'd1);
    end
    @(negedge clk);
    chk("wb_single", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lits [3];
    lits[0] = 32'h11; lits[1] = 32'h22; lits[2] = 32'h33;

    // Reset state; ex_valid is driven during reset and must be ignored.
    ex_valid = 1'b1; aluresult = 32'h55;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b0;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Non-memory ops back-to-back.
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; aluresult = lits[i]; rd_in = 5'(i + 1);
      push(1'b1, 5'(i + 1), lits[i], 1'b1, 1'b0);
      @(negedge clk);
      chk("nm_wb", {31'd0, wb_valid}, 32'd1);
      chk("nm_data", wb_data, lits[i]);
      chk("nm_no_req", {31'd0, dmem_req}, 32'd0);
    end
    ex_valid = 1'b0;
    @(negedge clk);

    // Stores.
    mem_op(1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00A5, 5'd4, 3, 0, 32'h0,
           32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    mem_op(1'b1, 2'd1, 1'b0, 32'h1002, 32'h1234_BEEF, 5'd5, 0, 0, 32'h0,
           32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    mem_op(1'b1, 2'd2, 1'b0, 32'h1004, 32'hCAFE_F00D, 5'd6, 1, 0, 32'h0,
           32'h1004, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // Loads.
    mem_op(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 5'd7, 0, 2, 32'h8001_1234,
           32'h2000, 4'b1100, 32'h0, 32'hFFFF_8001);
    mem_op(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 5'd8, 1, 2, 32'h8001_1234,
           32'h2000, 4'b1100, 32'h0, 32'h0000_8001);
    mem_op(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 5'd9, 0, 1, 32'h0000_F000,
           32'h2000, 4'b0010, 32'h0, 32'hFFFF_FFF0);
    mem_op(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 5'd10, 0, 1, 32'h0000_F000,
           32'h2000, 4'b0010, 32'h0, 32'h0000_00F0);
    mem_op(1'b0, 2'd2, 1'b1, 32'h2008, 32'h0, 5'd11, 2, 1, 32'h89AB_CDEF,
           32'h2008, 4'b1111, 32'h0, 32'h89AB_CDEF);
    mem_op(1'b0, 2'd3, 1'b0, 32'h200C, 32'h0, 5'd12, 0, 1, 32'h7654_3210,
           32'h200C, 4'b1111, 32'h0, 32'h7654_3210);

    // Reset while waiting for read data; the late rvalid must be ignored.
    ex_valid = 1'b1; mem_rd = 1'b1; mem_size = 2'd2; aluresult = 32'h4000; rd_in = 5'd13;
    @(negedge clk);
    ex_valid = 1'b0; mem_rd = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rs_in_wait", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("rs_ready", {31'd0, ex_ready}, 32'd1);
    chk("rs_no_req", {31'd0, dmem_req}, 32'd0);
    chk("rs_no_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("rs_no_wb2", {31'd0, wb_valid}, 32'd0);
    ex_valid = 1'b1; aluresult = 32'h77; rd_in = 5'd14;
    push(1'b1, 5'd14, 32'h77, 1'b1, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("rs_after_wb", {31'd0, wb_valid}, 32'd1);
    chk("rs_after_data", wb_data, 32'h77);
    @(negedge clk);

    // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; mem_rd = 1'b1; mem_size = 2'd2; aluresult = 32'h3002; rd_in = 5'd15;
    push(1'b0, 5'd15, 32'h3002, 1'b1, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0; mem_rd = 1'b0;
    chk("trap_no_req", {31'd0, dmem_req}, 32'd0);
    chk("trap_wb", {31'd0, wb_valid}, 32'd1);
    chk("trap_exc", {31'd0, exc_misalign}, 32'd1);
    chk("trap_data", wb_data, 32'h3002);
    chk("trap_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    chk("trap_pulse", {31'd0, exc_misalign}, 32'd0);
`else
    mem_op(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 5'd15, 0, 1, 32'h1234_5678,
           32'h3000, 4'b1111, 32'h0, 32'h1234_5678);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX-stage ALU in the single-issue pipeline.
- Takes the ALU result as an effective address, or passes it through for non-memory instructions.
- Runs a req/gnt/rvalid handshake to data memory, generates byte enables, aligns and sign-extends load data, and presents one writeback record per accepted instruction.
- Stalls EX (ex_ready low) while a memory transaction is outstanding.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = DW/8 = 4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept; high exactly when state==IDLE
- mem_rd  in  1  load
- mem_wr  in  1  store (mem_rd&mem_wr never both set)
- mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- mem_unsigned  in  1  zero-extend load
- aluresult  in  32  effective address, or pass-through result
- dreg  in  32  store data
- rd_in  in  5  destination register
- dmem_req  out  1  memory request, held until dmem_gnt
- dmem_we  out  1  write request
- dmem_addr  out  32  word address, aluresult with [1:0] forced to 0
- dmem_wdata  out  32  store data replicated to lanes
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid; never in the same cycle as its gnt
- dmem_rdata  in  32  read data
- wb_valid  out  1  one-cycle pulse per completed instruction
- wb_wen  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- exc_misalign  out  1  misalignment flag; tied 0 unless feature enabled

Behaviour:
- Reset: state=IDLE; dmem_req, dmem_we, wb_valid, wb_wen, exc_misalign = 0; dmem_addr, dmem_wdata, wb_data, wb_rd = 0; dmem_be = 0. ex_valid is ignored while rst=1.
- Reset mid-transaction: abandons the transaction and returns to IDLE. A late rvalid/gnt arriving in IDLE is ignored.
- Accept: ex_valid & ex_ready. Operands, op and rd are registered on accept.
- Non-memory (mem_rd=mem_wr=0): no bus activity. Next cycle: wb_valid=1, wb_wen=1, wb_data=aluresult. Latency 1; back-to-back every cycle.
- States: IDLE, REQ, WAIT_R.
  - IDLE --accept load/store--> REQ. dmem_req is asserted from the cycle after accept.
  - REQ: dmem_req=1 with addr/we/be/wdata stable until gnt.
  - REQ --gnt & store--> IDLE; wb_valid=1, wb_wen=0 in the same cycle the state returns to IDLE (registered, one cycle after gnt).
  - REQ --gnt & load--> WAIT_R; dmem_req drops the cycle after gnt.
  - WAIT_R --rvalid--> IDLE; next cycle wb_valid=1, wb_wen=1, wb_data=extended load data.
- Minimum latency: load 3 cycles, store 2 cycles (accept to wb_valid, zero-wait memory).
- Byte enables:
  - byte: 1<<a[1:0]
  - half: a[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Store data lanes: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
- Load extract: byte lane a[1:0], half lane a[1]. Sign-extend unless mem_unsigned; word is unaffected by mem_unsigned.
- Misaligned access (half with a[0]=1, word with a[1:0]≠0), feature off: low bits are ignored, so the access is forced aligned.
- wb_valid is never asserted two consecutive cycles for memory ops. WB never back-pressures.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned load/store issues no bus request and takes no FSM transition. The cycle after accept: wb_valid=1, wb_wen=0, exc_misalign=1 for one cycle, wb_data=faulting address.
- Undefined: exc_misalign is constant 0 and misaligned accesses are forced aligned as above.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state constants S_IDLE/S_REQ/S_WAIT_R
  - lane width constant
- One natural sub-module: mem_align, purely combinational. Computes be/wdata from size/a[1:0]/dreg, and extended load data from rdata/size/a[1:0]/unsigned. It is shared by the store and load paths.

Test Plan:
- Non-mem back-to-back: aluresult 0x11, 0x22, 0x33 on consecutive cycles → wb_data 0x11, 0x22, 0x33 on the next three cycles; wb_wen=1; dmem_req never high.
- Store byte, addr 0x1003, dreg 0xA5, gnt delayed 3 cycles → dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5 held stable; wb_valid(wen=0) one cycle after gnt.
- Load half signed, addr 0x2002, rdata 0x8001_1234, rvalid 2 cycles after gnt → wb_data=0xFFFF8001; same access unsigned → 0x00008001.
- Load byte signed, addr 0x2001, rdata 0x0000_F000 → wb_data=0xFFFFFFF0. Word load of 0x89ABCDEF → 0x89ABCDEF. ex_ready is low from accept to IDLE return.
- rst pulsed while in WAIT_R, then rvalid arrives → no wb_valid; state IDLE; ex_ready=1; next non-mem op completes normally.
- With MEM_MISALIGN_TRAP_EN, word load at 0x3002 → no dmem_req; next cycle wb_valid=1, wb_wen=0, exc_misalign=1, wb_data=0x3002. Without the macro → word read at 0x3000, be=4'b1111.
